tl_master_tile_stub: RTL
========================

// Module: tl_master_tile_stub
// PURPOSE
//  Parametrised, synthesisable TileLink-UL master standing in for the Rocket tile in subsystem benches.
//  Converts a simple command/response interface into single-beat Get/Put traffic on channel A.
//  Matches channel-D responses by source ID and returns them on the response port.
//  Tracks up to 2**SRC_W outstanding requests. Ties off B/C/E and records protocol errors.
// PARAMETERS
//  DATA_W  64  data bus width in bits, power of 2, >=8; mask width is DATA_W/8
//  ADDR_W  32  address width
//  SRC_W   2   source-ID width; NSRC=2**SRC_W outstanding transactions max
// PORTS
//  clock              in   1          single clock, all logic rising-edge
//  reset              in   1          asynchronous, active-low reset
//  cmd_valid/ready    in/out 1        command handshake
//  cmd_write          in   1          1=Put, 0=Get
//  cmd_address        in   ADDR_W     byte address
//  cmd_size           in   4          log2 bytes; must be <= log2(DATA_W/8)
//  cmd_mask           in   DATA_W/8   byte lanes for writes
//  cmd_data           in   DATA_W     write data
//  quiesce            in   1          1 = accept no new commands
//  a_ready/a_valid    in/out 1        TL channel A handshake
//  a_opcode,a_param   out  3,3        opcode; param always 0
//  a_size,a_source    out  4,SRC_W    size / allocated source
//  a_address,a_mask,a_data out ADDR_W,DATA_W/8,DATA_W
//  b_ready out 1 (=1); c_valid out 1 (=0); e_valid out 1 (=0); other B/C/E fields ignored/zero
//  d_valid/d_ready    in/out 1        TL channel D handshake
//  d_opcode,d_source,d_data,d_error  in 3,SRC_W,DATA_W,1
//  rsp_valid/rsp_ready out/in 1       response handshake
//  rsp_write,rsp_source,rsp_data,rsp_error out 1,SRC_W,DATA_W,1
//  outstanding        out  SRC_W+1    number of allocated source IDs
//  idle               out  1          outstanding==0, a_valid==0, rsp_valid==0
//  proto_err          out  1          sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset (async assert, sync release): a_valid=0, rsp_valid=0, all sources free, outstanding=0, proto_err=0.
//   A reset mid-operation drops every in-flight request; no responses are replayed.
//  A stage: one-entry register. States EMPTY/FULL.
//   cmd_ready = !quiesce && (EMPTY || a_ready) && any source free.
//  Command handshake in cycle N:
//   - allocate the lowest-numbered free source; set a_valid in cycle N+1.
//   - opcode: Get=4 when !cmd_write. Otherwise PutFullData=0 if the mask covers all 2**size lanes at the
//     aligned offset, else PutPartialData=1.
//   - a_mask for Get is derived from size/address.
//  Misaligned command (address low bits not aligned to size), or size too large:
//   - the command is consumed (ready follows the same rule), proto_err is set, no A beat is issued and no
//     source is allocated.
//  a_valid stays high with stable fields until a_ready; FULL->EMPTY on a_ready unless a new command is
//   loaded in the same cycle (back-to-back: one beat per cycle).
//  D path: d_ready = !rsp_valid || rsp_ready (one-entry response buffer).
//   A D handshake in cycle M produces rsp_valid in M+1.
//   rsp_write=1 for AccessAck(0), 0 for AccessAckData(1); data/error are copied.
//   The source is freed in cycle M and is allocatable from cycle M+1, never in M itself.
//  D beat with an unallocated source or an opcode other than 0/1: sets proto_err and is dropped
//   (no rsp, no free).
//  Simultaneous allocate and free in one cycle: outstanding is unchanged. Allocations never exceed NSRC.
//  quiesce only gates cmd_ready; outstanding requests and responses complete normally.
// TESTING
//  Get addr 0x80000000, size 3 -> a_opcode=4, mask=0xFF, source 0; D AccessAckData data 0x1122334455667788
//   -> rsp_data equal, rsp_write=0.
//  Put size 2 at 0x...04, mask 0xF0 -> a_opcode=0; mask 0x30 -> a_opcode=1; D AccessAck -> rsp_write=1.
//  Issue 4 Gets with a_ready=1 and no D -> sources 0,1,2,3; cmd_ready=0 after the 4th; outstanding=4.
//   Free source 2 -> next command gets 2, one cycle later.
//  Out-of-order D for sources 3,0 -> rsp_source 3 then 0. D with a free source -> proto_err=1, no rsp.
//  Hold a_ready=0 for 5 cycles -> A fields stable. Hold rsp_ready=0 -> d_ready=0 after first response.
//  Assert reset with 2 outstanding -> a_valid=0, outstanding=0, idle=1. Misaligned size-3 at 0x4 -> proto_err=1.

Source files
------------

// File: rtl/tl_master_tile_stub_if.sv
// Command, TileLink A/B/C/D/E and response bundle for the tile stub.
// master: the stub; slave: whatever drives commands and answers TL.
interface tl_master_tile_stub_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int SRC_W  = 2
);
  localparam int MW = DATA_W / 8;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [3:0]        cmd_size;
  logic [MW-1:0]     cmd_mask;
  logic [DATA_W-1:0] cmd_data;
  logic              quiesce;

  logic              a_ready;
  logic              a_valid;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [3:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [MW-1:0]     a_mask;
  logic [DATA_W-1:0] a_data;

  logic              b_ready;
  logic              c_valid;
  logic              e_valid;

  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [SRC_W-1:0]  d_source;
  logic [DATA_W-1:0] d_data;
  logic              d_error;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [SRC_W-1:0]  rsp_source;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_error;

  logic [SRC_W:0]    outstanding;
  logic              idle;
  logic              proto_err;

  modport master (
    input  cmd_valid, cmd_write, cmd_address,
    input  cmd_size, cmd_mask, cmd_data, quiesce,
    output cmd_ready,
    input  a_ready,
    output a_valid, a_opcode, a_param, a_size,
    output a_source, a_address, a_mask, a_data,
    output b_ready, c_valid, e_valid,
    input  d_valid, d_opcode, d_source,
    input  d_data, d_error,
    output d_ready,
    input  rsp_ready,
    output rsp_valid, rsp_write, rsp_source,
    output rsp_data, rsp_error,
    output outstanding, idle, proto_err
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_address,
    output cmd_size, cmd_mask, cmd_data, quiesce,
    input  cmd_ready,
    output a_ready,
    input  a_valid, a_opcode, a_param, a_size,
    input  a_source, a_address, a_mask, a_data,
    input  b_ready, c_valid, e_valid,
    output d_valid, d_opcode, d_source,
    output d_data, d_error,
    input  d_ready,
    output rsp_ready,
    input  rsp_valid, rsp_write, rsp_source,
    input  rsp_data, rsp_error,
    input  outstanding, idle, proto_err
  );
endinterface

// File: rtl/tl_master_tile_stub.sv
// TileLink-UL single-beat master standing in for a tile:
// commands become Get/Put on A, D beats are matched by source.
module tl_master_tile_stub #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32,
  parameter int SRC_W  = 2
) (
  input  logic clock,
  input  logic reset,
  tl_master_tile_stub_if.master bus
);
  localparam int MW   = DATA_W / 8;
  localparam int LGB  = $clog2(MW);
  localparam int OW   = (LGB > 0) ? LGB : 1;
  localparam int NSRC = 2 ** SRC_W;

  typedef enum logic {A_EMPTY, A_FULL} a_st_e;

  a_st_e             r_a_st;
  logic [2:0]        r_a_opcode;
  logic [3:0]        r_a_size;
  logic [SRC_W-1:0]  r_a_source;
  logic [ADDR_W-1:0] r_a_address;
  logic [MW-1:0]     r_a_mask;
  logic [DATA_W-1:0] r_a_data;
  logic [NSRC-1:0]   r_busy;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [SRC_W-1:0]  r_rsp_source;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp_error;
  logic              r_proto_err;

  logic              w_any_free;
  logic [SRC_W-1:0]  w_free_idx;
  logic              w_cmd_ready;
  logic              w_cmd_fire;
  logic              w_bad;
  logic              w_alloc;
  logic [OW-1:0]     w_off;
  logic [MW-1:0]     w_lanes;
  logic [2:0]        w_opcode;
  logic [MW-1:0]     w_mask;
  logic              w_d_ready;
  logic              w_d_fire;
  logic              w_d_ok;
  logic [NSRC-1:0]   w_set;
  logic [NSRC-1:0]   w_clr;
  logic [SRC_W:0]    w_count;

  assign w_off = bus.cmd_address[OW-1:0];

  always_comb begin
    w_free_idx = '0;
    for (int i = NSRC - 1; i >= 0; i--)
      if (!r_busy[i]) w_free_idx = SRC_W'(i);
  end

  // Lanes covered by an aligned 2**size access at this offset.
  always_comb begin
    int off;
    off = (LGB > 0) ? int'(w_off) : 0;
    w_lanes = '0;
    w_bad = int'(bus.cmd_size) > LGB;
    for (int i = 0; i < MW; i++)
      if ((i >> bus.cmd_size) == (off >> bus.cmd_size))
        w_lanes[i] = 1'b1;
    if ((off & ((1 << bus.cmd_size) - 1)) != 0)
      w_bad = 1'b1;
  end

  always_comb begin
    w_opcode = 3'd4;
    w_mask = w_lanes;
    if (bus.cmd_write) begin
      w_mask = bus.cmd_mask & w_lanes;
      w_opcode = (w_mask == w_lanes) ? 3'd0 : 3'd1;
    end
  end

  assign w_any_free  = ~&r_busy;
  assign w_cmd_ready = !bus.quiesce && w_any_free &&
                       (r_a_st == A_EMPTY || bus.a_ready);
  assign w_cmd_fire  = bus.cmd_valid && w_cmd_ready;
  assign w_alloc     = w_cmd_fire && !w_bad;

  assign w_d_ready = !r_rsp_valid || bus.rsp_ready;
  assign w_d_fire  = bus.d_valid && w_d_ready;
  assign w_d_ok    = w_d_fire && r_busy[bus.d_source] &&
                     (bus.d_opcode == 3'd0 ||
                      bus.d_opcode == 3'd1);

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_alloc) w_set[w_free_idx] = 1'b1;
    if (w_d_ok) w_clr[bus.d_source] = 1'b1;
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NSRC; i++)
      w_count = w_count + {{SRC_W{1'b0}}, r_busy[i]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_a_st       <= A_EMPTY;
      r_a_opcode   <= '0;
      r_a_size     <= '0;
      r_a_source   <= '0;
      r_a_address  <= '0;
      r_a_mask     <= '0;
      r_a_data     <= '0;
      r_busy       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_write  <= 1'b0;
      r_rsp_source <= '0;
      r_rsp_data   <= '0;
      r_rsp_error  <= 1'b0;
      r_proto_err  <= 1'b0;
    end else begin
      unique case (r_a_st)
        A_EMPTY: if (w_alloc) r_a_st <= A_FULL;
        A_FULL:
          if (bus.a_ready && !w_alloc)
            r_a_st <= A_EMPTY;
        default: r_a_st <= A_EMPTY;
      endcase
      if (w_alloc) begin
        r_a_opcode  <= w_opcode;
        r_a_size    <= bus.cmd_size;
        r_a_source  <= w_free_idx;
        r_a_address <= bus.cmd_address;
        r_a_mask    <= w_mask;
        r_a_data    <= bus.cmd_data;
      end
      r_busy <= (r_busy | w_set) & ~w_clr;
      if (w_d_ok) begin
        r_rsp_valid  <= 1'b1;
        r_rsp_write  <= bus.d_opcode == 3'd0;
        r_rsp_source <= bus.d_source;
        r_rsp_data   <= bus.d_data;
        r_rsp_error  <= bus.d_error;
      end else if (bus.rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
      if ((w_cmd_fire && w_bad) ||
          (w_d_fire && !w_d_ok))
        r_proto_err <= 1'b1;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.a_valid     = r_a_st == A_FULL;
  assign bus.a_opcode    = r_a_opcode;
  assign bus.a_param     = 3'd0;
  assign bus.a_size      = r_a_size;
  assign bus.a_source    = r_a_source;
  assign bus.a_address   = r_a_address;
  assign bus.a_mask      = r_a_mask;
  assign bus.a_data      = r_a_data;
  assign bus.b_ready     = 1'b1;
  assign bus.c_valid     = 1'b0;
  assign bus.e_valid     = 1'b0;
  assign bus.d_ready     = w_d_ready;
  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_write   = r_rsp_write;
  assign bus.rsp_source  = r_rsp_source;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_error   = r_rsp_error;
  assign bus.outstanding = w_count;
  assign bus.idle        = w_count == '0 &&
                           r_a_st == A_EMPTY &&
                           !r_rsp_valid;
  assign bus.proto_err   = r_proto_err;
endmodule
